bfly_datapath: RTL
==================

// Module: bfly_datapath
// PURPOSE
//  Arithmetic datapath for one radix-2 FFT butterfly: Y = A + W*B, Z = A - W*B.
//  Sits directly downstream of the butterfly controller; consumes its one-hot strobes.
//  Latches complex operands from the switch bus and evaluates the butterfly in strobe-ordered steps.
//  Drives the selected result component to the display.
//  Fixed point throughout: Q1.(DW-1) two's complement.
// PARAMETERS
//  DW  8  component width (bits) of every real/imag value; W, B, A, Y, Z all Q1.(DW-1)
// PORTS
//  Clock         in   1     rising-edge clock
//  nReset        in   1     reset; synchronous, active-low
//  data_in       in   2*DW  operand bus {re[2DW-1:DW], im[DW-1:0]}, signed
//  clear         in   1     zero all state
//  store_W       in   1     latch W from data_in
//  store_B       in   1     latch B from data_in
//  store_A       in   1     latch A from data_in
//  calc_ReWB     in   1     compute Re(W*B)
//  calc_ImY      in   1     compute Im(W*B) into ImY
//  calc_ImZ      in   1     copy -Im(W*B) into ImZ
//  calc_ReZ2     in   1     add ImA into ImY/ImZ; form 2*ReA
//  calc_ReZ      in   1     ReZ = ReA - ReWB
//  calc_ReY      in   1     ReY = 2*ReA - (ReA - ReWB)
//  display_ReY   in   1     display select: ReY
//  display_ImY   in   1     display select: ImY
//  display_ReZ   in   1     display select: ReZ
//  display_ImZ   in   1     display select: ImZ
//  result        out  DW    displayed value, signed
//  result_valid  out  1     a display strobe was high last cycle
//  ovf           out  1     sticky overflow flag
// BEHAVIOUR
//  - All registers are updated at the rising edge of Clock.
//  - nReset low: all registers, result, result_valid and ovf = 0 at that edge.
//    Applies mid-sequence too; no partial result is kept.
//  - clear=1: same effect as reset. clear has priority over every other strobe.
//  - Strobes are one-hot. Should several be high together, apply them in the PORTS order listed; no error is raised.
//  - store_*: {re,im} <= data_in. The store takes effect on the edge at which the strobe is sampled high.
//  - Multiply: products are 2DW bits wide; sum of two products is 2DW+1 bits.
//    Rounding: add 2^(DW-2), then arithmetic shift right by DW-1; the result is reduced to DW bits.
//  - calc_ReWB: ReWB <= rnd(ReW*ReB - ImW*ImB).
//  - calc_ImY: ImWB <= rnd(ReW*ImB + ImW*ReB); ImY <= the same value.
//  - calc_ImZ: ImZ <= -ImWB.
//  - calc_ReZ2: ImY <= ImA + ImY; ImZ <= ImA + ImZ; T2 <= ReA<<<1 (held at DW+1 bits, never reduced).
//  - calc_ReZ: ReZ <= ReA - ReWB (full DW+1 value also kept in D).
//  - calc_ReY: ReY <= T2 - D.
//  - Every reduction to DW bits goes through the package function fit().
//  - display_X: result <= X and result_valid <= 1, both on the next edge (1-cycle latency).
//    When no display strobe is high: result holds its last value and result_valid <= 0.
//  - Operand and intermediate registers hold their value until reset, clear or their own strobe.
// CONFIGURATION
//  BFLY_SAT_EN defined: fit() saturates to [-2^(DW-1), 2^(DW-1)-1].
//    Any clipped reduction sets ovf; ovf holds until reset or clear.
//    Edge case: negating -2^(DW-1) gives 2^(DW-1)-1 and sets ovf.
//  BFLY_SAT_EN undefined: fit() truncates (two's-complement wrap). ovf is tied to 0.
// STRUCTURE
//  Package bfly_pkg holds:
//    - localparam BFLY_DW = 8
//    - typedef cplx_t: struct packed {logic signed [BFLY_DW-1:0] re, im;}
//    - functions rnd() and fit()
//  Sub-module bfly_cmul: combinational complex multiply.
//    Outputs: unreduced re and im sums, 2DW+1 bits each.
//  Top level: operand and intermediate registers, adders, display mux.
// TESTING (DW=8)
//  1. W=0x40_00, B=0x40_20, A=0x20_10 through the full strobe sequence:
//     ReY=0x40, ImY=0x20, ReZ=0x00, ImZ=0x00, ovf=0.
//  2. W=0x7F_00, B=0x7F_00, A=0x7F_7F: ReWB=0x7E, ReZ=0x01.
//     SAT_EN: ReY=0x7F, ovf=1. Without SAT_EN: ReY=0xFD, ovf=0.
//  3. W=0x80_00, B=0x80_00 (-1*-1):
//     SAT_EN: ReWB=0x7F, ovf=1. Without SAT_EN: ReWB=0x80.
//  4. display_ImY high for 3 cycles, then low:
//     result=ImY from the next edge; result_valid high 3 cycles; result held afterwards.
//  5. nReset low for 1 cycle right after calc_ReWB:
//     all outputs 0; a following calc_ReY gives ReY=0x00.
//  6. clear and store_W high in the same cycle: W stays 0, ovf cleared.

Source files
------------

// File: rtl/bfly_pkg.sv
// Shared types and fixed-point helpers for the radix-2 butterfly datapath.
// Build option: define BFLY_SAT_EN to make fit() saturate instead of wrap.
package bfly_pkg;

   localparam int BFLY_DW = 8;
   localparam int BFLY_PW = 2 * BFLY_DW + 1;  // width of a sum of two products

   typedef logic signed [BFLY_PW-1:0] wide_t;

   typedef struct packed {
      logic signed [BFLY_DW-1:0] re;
      logic signed [BFLY_DW-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic signed [BFLY_DW-1:0] val;
      logic                      clip;
   } fit_t;

   // Round-half-up back to Q1.(DW-1): add half an output LSB, then drop the fraction.
   function automatic wide_t rnd(input wide_t x);
      wide_t biased;
      biased = x + (wide_t'(1) <<< (BFLY_DW - 2));
      return biased >>> (BFLY_DW - 1);
   endfunction

   function automatic fit_t fit(input wide_t x);
      fit_t f;
`ifdef BFLY_SAT_EN
      if (x > wide_t'((1 <<< (BFLY_DW - 1)) - 1)) begin
         f.val  = {1'b0, {(BFLY_DW-1){1'b1}}};
         f.clip = 1'b1;
      end else if (x < -wide_t'(1 <<< (BFLY_DW - 1))) begin
         f.val  = {1'b1, {(BFLY_DW-1){1'b0}}};
         f.clip = 1'b1;
      end else begin
         f.val  = x[BFLY_DW-1:0];
         f.clip = 1'b0;
      end
`else
      f.val  = x[BFLY_DW-1:0];
      f.clip = 1'b0;
`endif
      return f;
   endfunction

endpackage

// File: rtl/bfly_if.sv
// Strobe, operand and display bus between the butterfly controller and datapath.
interface bfly_if;
   import bfly_pkg::*;

   cplx_t                     data_in;
   logic                      clear;
   logic                      store_W, store_B, store_A;
   logic                      calc_ReWB, calc_ImY, calc_ImZ;
   logic                      calc_ReZ2, calc_ReZ, calc_ReY;
   logic                      display_ReY, display_ImY, display_ReZ, display_ImZ;
   logic signed [BFLY_DW-1:0] result;
   logic                      result_valid;
   logic                      ovf;

   modport master (
      output data_in, clear, store_W, store_B, store_A,
             calc_ReWB, calc_ImY, calc_ImZ, calc_ReZ2, calc_ReZ, calc_ReY,
             display_ReY, display_ImY, display_ReZ, display_ImZ,
      input  result, result_valid, ovf
   );

   modport slave (
      input  data_in, clear, store_W, store_B, store_A,
             calc_ReWB, calc_ImY, calc_ImZ, calc_ReZ2, calc_ReZ, calc_ReY,
             display_ReY, display_ImY, display_ReZ, display_ImZ,
      output result, result_valid, ovf
   );

endinterface

// File: rtl/bfly_cmul.sv
// Combinational complex multiply W*B; sums are returned unrounded at 2*DW+1 bits.
module bfly_cmul
   import bfly_pkg::*;
(
   input  cplx_t w,
   input  cplx_t b,
   output wide_t re_sum,
   output wide_t im_sum
);

   logic signed [2*BFLY_DW-1:0] p_rr, p_ii, p_ri, p_ir;

   assign p_rr = $signed(w.re) * $signed(b.re);
   assign p_ii = $signed(w.im) * $signed(b.im);
   assign p_ri = $signed(w.re) * $signed(b.im);
   assign p_ir = $signed(w.im) * $signed(b.re);

   assign re_sum = wide_t'(p_rr) - wide_t'(p_ii);
   assign im_sum = wide_t'(p_ri) + wide_t'(p_ir);

endmodule

// File: rtl/bfly_datapath.sv
// Radix-2 butterfly datapath Y = A + W*B, Z = A - W*B, driven by one-hot strobes.
// Build option: BFLY_SAT_EN selects saturating reductions and a live ovf flag.
module bfly_datapath
   import bfly_pkg::*;
(
   input  logic  Clock,
   input  logic  nReset,
   bfly_if.slave bus
);

   localparam int DW = BFLY_DW;

   cplx_t                w_q, w_d, b_q, b_d, a_q, a_d;
   logic signed [DW-1:0] rewb_q, rewb_d, imwb_q, imwb_d;
   logic signed [DW-1:0] imy_q, imy_d, imz_q, imz_d;
   logic signed [DW-1:0] rez_q, rez_d, rey_q, rey_d;
   logic signed [DW-1:0] result_q, result_d;
   logic signed [DW:0]   t2_q, t2_d, d_q, d_d;
   logic                 result_valid_q, result_valid_d;
   logic                 ovf_q, ovf_d;

   wide_t re_sum, im_sum, diff;
   fit_t  r;
   logic  clip;

   // Operands are resolved first so a same-cycle store feeds the multiplier.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      w_d = w_q;
      b_d = b_q;
      a_d = a_q;
      if (bus.clear) begin
         w_d = '0;
         b_d = '0;
         a_d = '0;
      end else begin
         if (bus.store_W) w_d = bus.data_in;
         if (bus.store_B) b_d = bus.data_in;
         if (bus.store_A) a_d = bus.data_in;
      end
   end

   bfly_cmul u_cmul (
      .w      (w_d),
      .b      (b_d),
      .re_sum (re_sum),
      .im_sum (im_sum)
   );

   // Each step reads the _d results of earlier steps, so coincident strobes chain in order.
   always_comb begin
      rewb_d         = rewb_q;
      imwb_d         = imwb_q;
      imy_d          = imy_q;
      imz_d          = imz_q;
      t2_d           = t2_q;
      d_d            = d_q;
      rez_d          = rez_q;
      rey_d          = rey_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      ovf_d          = ovf_q;
      r              = '0;
      diff           = '0;
      clip           = 1'b0;
      if (bus.clear) begin
         rewb_d   = '0;
         imwb_d   = '0;
         imy_d    = '0;
         imz_d    = '0;
         t2_d     = '0;
         d_d      = '0;
         rez_d    = '0;
         rey_d    = '0;
         result_d = '0;
         ovf_d    = 1'b0;
      end else begin
         if (bus.calc_ReWB) begin
            r = fit(rnd(re_sum));  rewb_d = r.val;  clip = clip | r.clip;
         end
         if (bus.calc_ImY) begin
            r = fit(rnd(im_sum));  imwb_d = r.val;  imy_d = r.val;  clip = clip | r.clip;
         end
         if (bus.calc_ImZ) begin
            r = fit(-wide_t'(imwb_d));  imz_d = r.val;  clip = clip | r.clip;
         end
         if (bus.calc_ReZ2) begin
            r = fit(wide_t'($signed(a_d.im)) + wide_t'(imy_d));  imy_d = r.val;  clip = clip | r.clip;
            r = fit(wide_t'($signed(a_d.im)) + wide_t'(imz_d));  imz_d = r.val;  clip = clip | r.clip;
            t2_d = $signed({a_d.re, 1'b0});
         end
         if (bus.calc_ReZ) begin
            diff  = wide_t'($signed(a_d.re)) - wide_t'(rewb_d);
            d_d   = diff[DW:0];
            r     = fit(diff);
            rez_d = r.val;
            clip  = clip | r.clip;
         end
         if (bus.calc_ReY) begin
            r = fit(wide_t'(t2_d) - wide_t'(d_d));  rey_d = r.val;  clip = clip | r.clip;
         end
         if (bus.display_ReY) begin result_d = rey_d; result_valid_d = 1'b1; end
         if (bus.display_ImY) begin result_d = imy_d; result_valid_d = 1'b1; end
         if (bus.display_ReZ) begin result_d = rez_d; result_valid_d = 1'b1; end
         if (bus.display_ImZ) begin result_d = imz_d; result_valid_d = 1'b1; end
         ovf_d = ovf_q | clip;
      end
   end

   always_ff @(posedge Clock) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (!nReset) begin
         w_q            <= '0;
         b_q            <= '0;
         a_q            <= '0;
         rewb_q         <= '0;
         imwb_q         <= '0;
         imy_q          <= '0;
         imz_q          <= '0;
         t2_q           <= '0;
         d_q            <= '0;
         rez_q          <= '0;
         rey_q          <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         ovf_q          <= 1'b0;
      end else begin
         w_q            <= w_d;
         b_q            <= b_d;
         a_q            <= a_d;
         rewb_q         <= rewb_d;
         imwb_q         <= imwb_d;
         imy_q          <= imy_d;
         imz_q          <= imz_d;
         t2_q           <= t2_d;
         d_q            <= d_d;
         rez_q          <= rez_d;
         rey_q          <= rey_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         ovf_q          <= ovf_d;
      end
   end

   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
   assign bus.ovf          = ovf_q;

endmodule
